// File: rtl/fifo_write_arbiter_pkg.sv
// Shared definitions for the FIFO write arbiter: default widths, tag sizing and
// the layout of a FIFO word ({channel tag, payload}, tag in the MSBs).
package fifo_write_arbiter_pkg;

   localparam int DATA_BITS_DEFAULT = 8;
   localparam int CHANNELS_DEFAULT  = 4;

   // A single channel still needs one tag bit so the word layout stays uniform.
   function automatic int tag_bits(input int channels);
      return (channels <= 1) ? 1 : $clog2(channels);
   endfunction

   localparam int TAG_BITS_DEFAULT = tag_bits(CHANNELS_DEFAULT);

   typedef struct packed {
      logic [TAG_BITS_DEFAULT-1:0]  tag;
      logic [DATA_BITS_DEFAULT-1:0] payload;
   } fifo_word_t;

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// FIFO write-port handshake: the arbiter is the master, the FIFO the slave.
interface fifo_write_arbiter_if
   import fifo_write_arbiter_pkg::*;
#(
   parameter int DATA_BITS    = DATA_BITS_DEFAULT,
   parameter int CHANNEL_BITS = TAG_BITS_DEFAULT
);

   logic                              fifo_write;
   logic [CHANNEL_BITS+DATA_BITS-1:0] fifo_write_data;
   logic                              fifo_write_ready;

   modport master (
      output fifo_write,
      output fifo_write_data,
      input  fifo_write_ready
   );

   modport slave (
      input  fifo_write,
      input  fifo_write_data,
      output fifo_write_ready
   );

endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit at or after the
// pointer, searching upward and wrapping from N-1 back to 0.
module rr_pick #(
   parameter int N        = 4,
   parameter int IDX_BITS = 2
) (
   input  logic [N-1:0]        request,
   input  logic [IDX_BITS-1:0] pointer,
   output logic                valid,
   output logic [IDX_BITS-1:0] index
);

   int slot;

   // NOTE: every always_comb output gets a default first, so no path can leave
   // it unassigned and infer a latch.
   always_comb begin
      valid = 1'b0;
      index = '0;
      slot  = 0;
      for (int i = 0; i < N; i++) begin
         slot = int'(pointer) + i;
         if (slot >= N) slot = slot - N;
         if (!valid && request[slot]) begin
            valid = 1'b1;
            index = IDX_BITS'(slot);
         end
      end
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Shares one FIFO write port between CHANNELS byte producers, each with a
// 1-entry holding slot, drained round-robin and tagged with its source channel.
module fifo_write_arbiter
   import fifo_write_arbiter_pkg::*;
#(
   parameter int DATA_BITS    = DATA_BITS_DEFAULT,
   parameter int CHANNELS     = CHANNELS_DEFAULT,
   parameter int CHANNEL_BITS = tag_bits(CHANNELS),
   parameter int DROP_BITS    = 8
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [CHANNELS-1:0]           ch_enable_i,
   input  logic [CHANNELS-1:0]           ch_write_i,
   input  logic [CHANNELS*DATA_BITS-1:0] ch_data_i,
   output logic [CHANNELS-1:0]           ch_ready_o,
   fifo_write_arbiter_if.master          fifo,
   input  logic                          clear_errors_i,
   output logic [CHANNELS-1:0]           ch_dropped_o,
   output logic [DROP_BITS-1:0]          drop_count_o
);

   logic [CHANNELS-1:0]     pending;
   logic [DATA_BITS-1:0]    slot_data [CHANNELS];
   logic [CHANNEL_BITS-1:0] pointer;

   logic [CHANNELS-1:0]     request;
   logic [CHANNELS-1:0]     grant_onehot;
   logic [CHANNELS-1:0]     write_req;
   logic [CHANNELS-1:0]     accept;
   logic [CHANNELS-1:0]     drop;
   logic                    grant_valid;
   logic [CHANNEL_BITS-1:0] grant_idx;
   logic [DROP_BITS:0]      drop_sum;
   logic [DROP_BITS-1:0]    drop_next;

   // A disabled channel keeps its word but is invisible to the arbiter.
   assign request = fifo.fifo_write_ready ? (pending & ch_enable_i) : '0;

   rr_pick #(
      .N        (CHANNELS),
      .IDX_BITS (CHANNEL_BITS)
   ) u_rr_pick (
      .request (request),
      .pointer (pointer),
      .valid   (grant_valid),
      .index   (grant_idx)
   );

   always_comb begin
      grant_onehot = '0;
      if (grant_valid) grant_onehot[grant_idx] = 1'b1;
   end

   assign fifo.fifo_write      = grant_valid;
   assign fifo.fifo_write_data = grant_valid ? {grant_idx, slot_data[grant_idx]} : '0;

   // A slot draining this cycle can be refilled in the same cycle.
   assign write_req  = ch_write_i & ch_enable_i;
   assign accept     = write_req & (~pending | grant_onehot);
   assign drop       = write_req & pending & ~grant_onehot;
   assign ch_ready_o = ~pending;

   assign drop_sum  = {1'b0, drop_count_o} + (DROP_BITS+1)'($countones(drop));
   assign drop_next = drop_sum[DROP_BITS] ? '1 : drop_sum[DROP_BITS-1:0];

   // NOTE: sequential state is written with non-blocking assignments so every
   // register samples the pre-edge values, independent of statement order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pending      <= '0;
         pointer      <= '0;
         ch_dropped_o <= '0;
         drop_count_o <= '0;
      end else begin
         pending <= (pending & ~grant_onehot) | accept;
         if (grant_valid) begin
            pointer <= (grant_idx == CHANNEL_BITS'(CHANNELS-1)) ? '0 : grant_idx + 1'b1;
         end
         if (clear_errors_i) begin
            ch_dropped_o <= '0;
            drop_count_o <= '0;
         end else begin
            ch_dropped_o <= ch_dropped_o | drop;
            drop_count_o <= drop_next;
         end
      end
   end

   // NOTE: the slot payload registers have no reset; pending qualifies them, and
   // the output mux forces zero whenever nothing is granted.
   always_ff @(posedge clock) begin
      for (int k = 0; k < CHANNELS; k++) begin
         if (accept[k]) slot_data[k] <= ch_data_i[k*DATA_BITS +: DATA_BITS];
      end
   end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed self-checking bench for fifo_write_arbiter with hand-computed
// expected FIFO words, ready masks and drop counts.
module tb_fifo_write_arbiter;
   import fifo_write_arbiter_pkg::*;

   logic        clock;
   logic        reset;
   logic [3:0]  ch_enable;
   logic [3:0]  ch_write;
   logic [31:0] ch_data;
   logic [3:0]  ch_ready;
   logic        clear_errors;
   logic [3:0]  ch_dropped;
   logic [7:0]  drop_count;

   int checks = 0;
   int errors = 0;

   fifo_write_arbiter_if #(.DATA_BITS(8), .CHANNEL_BITS(2)) fifo_if ();

   fifo_write_arbiter #(
      .DATA_BITS    (8),
      .CHANNELS     (4),
      .CHANNEL_BITS (2),
      .DROP_BITS    (8)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .ch_enable_i    (ch_enable),
      .ch_write_i     (ch_write),
      .ch_data_i      (ch_data),
      .ch_ready_o     (ch_ready),
      .fifo           (fifo_if),
      .clear_errors_i (clear_errors),
      .ch_dropped_o   (ch_dropped),
      .drop_count_o   (drop_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] word(input logic [1:0] tag, input logic [7:0] payload);
      fifo_word_t w;
      w.tag     = tag;
      w.payload = payload;
      return 32'(w);
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      @(posedge clock);
      #3;
      reset = 1'b1;
   endtask

   task automatic expect_write(input string tag, input logic [31:0] exp_word);
      check({tag, "_wr"}, 32'(fifo_if.fifo_write), 32'd1);
      check({tag, "_data"}, 32'(fifo_if.fifo_write_data), exp_word);
   endtask

   task automatic expect_idle(input string tag);
      check({tag, "_wr"}, 32'(fifo_if.fifo_write), 32'd0);
      check({tag, "_data"}, 32'(fifo_if.fifo_write_data), 32'd0);
   endtask

   initial begin
      reset        = 1'b0;
      ch_enable    = 4'hF;
      ch_write     = 4'h0;
      ch_data      = '0;
      clear_errors = 1'b0;
      fifo_if.fifo_write_ready = 1'b1;

      // 1: reset state, single strobe latency
      #12;
      check("rst_ready", 32'(ch_ready), 32'hF);
      expect_idle("rst");
      check("rst_dropped", 32'(ch_dropped), 32'h0);
      check("rst_count", 32'(drop_count), 32'h0);
      @(posedge clock);
      #3;
      reset = 1'b1;
      ch_write = 4'b0010;
      ch_data[15:8] = 8'h41;
      #1;
      check("t1_ready_pre", 32'(ch_ready), 32'hF);
      tick();
      ch_write = 4'h0;
      #1;
      check("t1_ready_busy", 32'(ch_ready), 32'hD);
      expect_write("t1", word(2'd1, 8'h41));
      tick();
      check("t1_ready_back", 32'(ch_ready), 32'hF);
      expect_idle("t1_after");

      // 2: simultaneous strobes drain in order 0..3, pointer wraps to 0
      apply_reset();
      ch_write = 4'hF;
      ch_data  = 32'h44434241;
      tick();
      ch_write = 4'h0;
      #1;
      for (int i = 0; i < 4; i++) begin
         expect_write($sformatf("t2_w%0d", i), word(2'(i), 8'(8'h41 + i)));
         tick();
      end
      expect_idle("t2_done");
      ch_write = 4'b1001;
      ch_data  = 32'h53000050;
      tick();
      ch_write = 4'h0;
      #1;
      expect_write("t2_ptr0", word(2'd0, 8'h50));
      tick();
      expect_write("t2_ptr3", word(2'd3, 8'h53));
      tick();
      expect_idle("t2_end");

      // 3: drop while FIFO full, single write after ready, clear
      apply_reset();
      fifo_if.fifo_write_ready = 1'b0;
      ch_write = 4'b0100;
      ch_data[23:16] = 8'h41;
      tick();
      ch_data[23:16] = 8'h42;
      tick();
      ch_write = 4'h0;
      #1;
      check("t3_dropped", 32'(ch_dropped), 32'h4);
      check("t3_count", 32'(drop_count), 32'd1);
      check("t3_ready", 32'(ch_ready), 32'hB);
      expect_idle("t3_full");
      fifo_if.fifo_write_ready = 1'b1;
      #1;
      expect_write("t3_drain", word(2'd2, 8'h41));
      tick();
      expect_idle("t3_once");
      clear_errors = 1'b1;
      tick();
      clear_errors = 1'b0;
      #1;
      check("t3_clr_flag", 32'(ch_dropped), 32'h0);
      check("t3_clr_count", 32'(drop_count), 32'd0);

      // popcount of simultaneous drops, clear beats drops, saturation, hold
      fifo_if.fifo_write_ready = 1'b0;
      ch_write = 4'hF;
      ch_data  = 32'hA3A2A1A0;
      tick();
      check("pc_fill_count", 32'(drop_count), 32'd0);
      ch_data = 32'hEEEEEEEE;
      tick();
      check("pc_count4", 32'(drop_count), 32'd4);
      check("pc_flags", 32'(ch_dropped), 32'hF);
      clear_errors = 1'b1;
      tick();
      clear_errors = 1'b0;
      #1;
      check("pc_clear_wins", 32'(drop_count), 32'd0);
      check("pc_clear_flags", 32'(ch_dropped), 32'h0);
      repeat (70) tick();
      check("pc_saturate", 32'(drop_count), 32'hFF);
      ch_write = 4'h0;
      clear_errors = 1'b1;
      tick();
      clear_errors = 1'b0;
      fifo_if.fifo_write_ready = 1'b1;
      #1;
      check("pc_cleared", 32'(drop_count), 32'd0);
      expect_write("pc_w3", word(2'd3, 8'hA3));
      tick();
      expect_write("pc_w0", word(2'd0, 8'hA0));
      tick();
      expect_write("pc_w1", word(2'd1, 8'hA1));
      tick();
      expect_write("pc_w2", word(2'd2, 8'hA2));
      tick();
      expect_idle("pc_end");

      // 4: continuous strobes on ch0, same-cycle grant and refill
      apply_reset();
      ch_write = 4'b0001;
      ch_data[7:0] = 8'h10;
      tick();
      for (int i = 1; i < 6; i++) begin
         ch_data[7:0] = 8'(8'h10 + i);
         #1;
         expect_write($sformatf("t4_w%0d", i), word(2'd0, 8'(8'h10 + i - 1)));
         tick();
      end
      ch_write = 4'h0;
      #1;
      expect_write("t4_last", word(2'd0, 8'h15));
      tick();
      expect_idle("t4_end");
      check("t4_count", 32'(drop_count), 32'd0);
      check("t4_flags", 32'(ch_dropped), 32'h0);

      // 5: disabled channels ignore strobes and hold pending words
      apply_reset();
      ch_enable = 4'b1110;
      ch_write  = 4'b0001;
      ch_data[7:0] = 8'h55;
      tick();
      ch_write = 4'h0;
      #1;
      check("t5_ignored", 32'(ch_ready), 32'hF);
      check("t5_no_drop", 32'(ch_dropped), 32'h0);
      expect_idle("t5_no_cap");
      ch_enable = 4'hF;
      fifo_if.fifo_write_ready = 1'b0;
      ch_write = 4'b0010;
      ch_data[15:8] = 8'h66;
      tick();
      ch_write  = 4'h0;
      ch_enable = 4'b1101;
      fifo_if.fifo_write_ready = 1'b1;
      #1;
      expect_idle("t5_held");
      check("t5_held_ready", 32'(ch_ready), 32'hD);
      tick();
      expect_idle("t5_still_held");
      ch_enable = 4'hF;
      #1;
      expect_write("t5_release", word(2'd1, 8'h66));
      tick();
      expect_idle("t5_end");

      // 6: reset mid-cycle discards a pending word silently
      fifo_if.fifo_write_ready = 1'b0;
      ch_write = 4'b1000;
      ch_data[31:24] = 8'h77;
      tick();
      ch_write = 4'h0;
      #1;
      check("t6_pending", 32'(ch_ready), 32'h7);
      #1;
      reset = 1'b0;
      fifo_if.fifo_write_ready = 1'b1;
      #1;
      check("t6_rst_ready", 32'(ch_ready), 32'hF);
      expect_idle("t6_rst");
      check("t6_rst_count", 32'(drop_count), 32'd0);
      @(posedge clock);
      #3;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_idle($sformatf("t6_post%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
